// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the repeated-addition multiplier
//                front-end: FSM state encoding, data width and the default
//                watchdog limit.
//  Contents    : MUL_WIDTH   - operand/product width of the multiplier bus
//                MUL_TIMEOUT - default WAIT-state watchdog limit
//                mul_state_e - sequencer state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int unsigned MUL_WIDTH   = 16;
    // Must exceed 2^MUL_WIDTH plus controller overhead so that a legal
    // worst-case multiply never trips the watchdog.
    localparam int unsigned MUL_TIMEOUT = 65600;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mul_watchdog
//  Description : Clearable up-counter with a terminal-count flag. Clear has
//                priority over enable; the flag is high while the count
//                equals TIMEOUT-1.
//  Ports       : clk_i   - rising-edge clock
//                rst_ni  - synchronous active-low reset (count to zero)
//                clr_i   - clear the count to zero
//                en_i    - increment the count
//                tc_o    - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_watchdog
    import mul_pkg::*;
#(
    parameter int unsigned TIMEOUT = MUL_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + c_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == c_TERM);

endmodule
`default_nettype wire

// File: rtl/mul_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_operand_sequencer
//  Description : Front-end for the repeated-addition multiplier. Accepts an
//                operand pair, serialises A then B onto the core data bus
//                with a one-cycle start pulse, waits for done and returns
//                the product on a valid/ready port. Zero operands bypass the
//                core; a watchdog aborts a core that never signals done.
//  Ports       : clk, rst_n                  - clock, sync active-low reset
//                op_valid/op_ready/op_a/op_b - operand handshake
//                res_valid/res_ready         - result handshake
//                res_product/res_timeout     - product (mod 2^WIDTH), abort
//                core_data_in/core_start     - drive the multiplier
//                core_done/core_y            - multiplier status/product
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = MUL_WIDTH,
    parameter int unsigned TIMEOUT = MUL_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_product,
    output logic             res_timeout,
    output logic [WIDTH-1:0] core_data_in,
    output logic             core_start,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_y
);

    mul_state_e       state_q;
    logic             op_ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_product_q;
    logic             res_timeout_q;
    logic [WIDTH-1:0] core_data_in_q;
    logic             core_start_q;
    logic [WIDTH-1:0] b_q;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_tc;

    // Clearing in LOAD_B means the count is zero in the first WAIT cycle,
    // so the terminal count lands in WAIT cycle number TIMEOUT.
    assign w_wd_clr = (state_q == LOAD_B);
    assign w_wd_en  = (state_q == WAIT);

    mul_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (w_wd_clr),
        .en_i   (w_wd_en),
        .tc_o   (w_wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_ready_q     <= 1'b1;
            res_valid_q    <= 1'b0;
            res_product_q  <= '0;
            res_timeout_q  <= 1'b0;
            core_data_in_q <= '0;
            core_start_q   <= 1'b0;
            b_q            <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        b_q        <= op_b;
                        op_ready_q <= 1'b0;
                        if ((op_a == '0) || (op_b == '0)) begin
                            // Product is trivially zero: skip the core.
                            res_valid_q   <= 1'b1;
                            res_product_q <= '0;
                            res_timeout_q <= 1'b0;
                            state_q       <= RESP;
                        end else begin
                            core_data_in_q <= op_a;
                            core_start_q   <= 1'b1;
                            state_q        <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    core_data_in_q <= b_q;
                    core_start_q   <= 1'b0;
                    state_q        <= LOAD_B;
                end
                LOAD_B: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Done is tested first so a done coinciding with the
                    // terminal count still returns the real product.
                    if (core_done) begin
                        res_valid_q   <= 1'b1;
                        res_product_q <= core_y;
                        res_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (w_wd_tc) begin
                        res_valid_q   <= 1'b1;
                        res_product_q <= '0;
                        res_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q  <= 1'b0;
                    core_start_q <= 1'b0;
                    op_ready_q   <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst_n keeps op_ready low for as long as reset is held.
    assign op_ready     = op_ready_q & rst_n;
    assign res_valid    = res_valid_q;
    assign res_product  = res_product_q;
    assign res_timeout  = res_timeout_q;
    assign core_data_in = core_data_in_q;
    assign core_start   = core_start_q;

endmodule
`default_nettype wire

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
Front-end sequencer for the repeated-addition multiplier (mul_datapath + controller pair).
- Accepts an operand pair on a valid/ready handshake.
- Serialises the pair onto the multiplier's shared data_in bus (A, then B) and pulses start.
- Waits for done, captures Y and returns it on a valid/ready result port.
- Short-circuits zero operands and guards against a hung multiplier with a watchdog.

Parameters:
WIDTH, 16, operand/product width; matches the multiplier data bus.
TIMEOUT, 65600, maximum cycles in WAIT before abort; must exceed 2^WIDTH plus controller overhead.

Ports:
clk  input  1  rising-edge clock, shared with the multiplier
rst_n  input  1  synchronous active-low reset
op_valid  input  1  operand pair offered
op_ready  output  1  sequencer can accept a pair (high only in IDLE)
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier (repeat count)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_product  output  WIDTH  product, low WIDTH bits (truncated)
res_timeout  output  1  result is an abort; qualified by res_valid
core_data_in  output  WIDTH  drives the multiplier data_in bus
core_start  output  1  multiplier start
core_done  input  1  multiplier done
core_y  input  WIDTH  multiplier product Y

Behaviour:
- Reset (rst_n low at clk edge), regardless of state:
  - State goes to IDLE.
  - op_ready=0 during reset, 1 from the first cycle after.
  - res_valid=0, res_product=0, res_timeout=0, core_start=0, core_data_in=0, watchdog=0.
  - Reset mid-operation abandons the job with no result. The multiplier is reset by its own means; this block does not reset it.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, register op_a/op_b.
  - If op_a==0 or op_b==0: go to RESP with res_product=0, res_timeout=0. The core is not started.
  - Otherwise go to LOAD_A.
- LOAD_A: exactly one cycle; core_data_in=A, core_start=1; go to LOAD_B.
- LOAD_B: exactly one cycle; core_data_in=B, core_start=0; go to WAIT.
- WAIT:
  - core_data_in holds B and the watchdog increments each cycle.
  - On core_done=1: capture core_y into res_product, go to RESP.
  - If the watchdog reaches TIMEOUT-1 with no done: res_product=0, res_timeout=1, go to RESP.
  - If done and timeout coincide in the same cycle, done wins (valid product, res_timeout=0).
- RESP:
  - res_valid=1; outputs held stable until res_ready.
  - On res_ready go to IDLE; res_valid drops the next cycle and op_ready rises that same cycle.
  - No back-to-back accept: each job costs one IDLE cycle minimum.
- core_done is ignored outside WAIT; stray pulses have no effect.
- Latency, non-zero operands: accept edge, then LOAD_A, LOAD_B, WAIT (N cycles), RESP. res_valid rises 3+N cycles after accept, where N is the number of WAIT cycles up to and including the one that samples core_done.
- Latency, zero operand: res_valid rises 1 cycle after accept.
- Arithmetic: no widening; the product is whatever the core returns, modulo 2^WIDTH.
- Watchdog width: $clog2(TIMEOUT+1) bits, cleared on entry to WAIT.

Decomposition:
- Shared package mul_pkg:
  - State enum (IDLE, LOAD_A, LOAD_B, WAIT, RESP).
  - MUL_WIDTH constant.
  - Default TIMEOUT constant.
- Sub-module mul_watchdog: a clearable counter with a terminal-count flag.
- FSM and registers stay in the top module.

Test Plan:
- op_a=4, op_b=3, core model raises done after 3 adds with Y=12 → core_data_in=4 with core_start=1 for one cycle, then 3 → res_valid, res_product=12, res_timeout=0.
- op_a=0, op_b=9 → core_start never asserted; res_valid 1 cycle after accept with res_product=0.
- op_a=7, op_b=5, res_ready held low 10 cycles → res_product=35 stable and op_ready=0 throughout; accept on release, op_ready=1 the next cycle.
- Core model never raises done, TIMEOUT=20 → res_valid after 20 WAIT cycles with res_timeout=1, res_product=0.
- rst_n low for 1 cycle during WAIT → next cycle IDLE, op_ready=1, res_valid=0; a later core_done pulse is ignored.
- op_a=300, op_b=300, core Y=0x5F90 (90000 mod 2^16) → res_product=0x5F90; done raised in the cycle the watchdog hits TIMEOUT-1 → valid product, res_timeout=0.
